// File: rtl/vga_line_fetch_sched.sv
// vga_line_fetch_sched
// Line-fetch scheduler for the VGA display path. On each line's horizontal
// blanking (x == H_DISP) it issues the burst reads that bring the next visible
// line into the line buffer. It raises line_ready when the line is complete and
// pulses underrun when a visible line starts before its fetch has finished.
//
// Optional feature macro: VGA_FETCH_STATS_EN
//   defined   : underrun_cnt counts underrun pulses, saturating at 16'hFFFF
//   undefined : no counter logic, underrun_cnt is tied to 0
//
// Read handshake: rd_req is a valid; rd_ack is its ready. A request is
// transferred in the cycle where rd_req && rd_ack. rd_addr/rd_len are stable
// from the rise of rd_req until that cycle, and rd_req drops the cycle after.
// rd_done then closes the outstanding burst with a single-cycle pulse.
`timescale 1ns/1ps

module vga_line_fetch_sched #(
    parameter int                H_DISP    = 1680,
    parameter int                V_DISP    = 1050,
    parameter int                V_TOTAL   = 1089,
    parameter int                BURST_LEN = 64,
    parameter int                ADDR_W    = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [11:0]       x,
    input  logic [10:0]       y,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_len,
    input  logic              rd_ack,
    input  logic              rd_done,
    output logic              line_ready,
    output logic              underrun,
    output logic [15:0]       underrun_cnt
);

    localparam int NB       = (H_DISP + BURST_LEN - 1) / BURST_LEN;
    localparam int LAST_LEN = H_DISP - (NB - 1) * BURST_LEN;
    localparam int BIDX_W   = $clog2(NB + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Observable FSM state (hierarchical probe point for checkers).
    state_t              state;
    logic [BIDX_W-1:0]   burst_idx;
    logic                pending;
    // Base address of the most recently accepted target line. While a fetch
    // is running and a retrigger arrives, this already holds the pending
    // line's base; the in-flight burst is unaffected because rd_addr is its
    // own register.
    logic [ADDR_W-1:0]   line_base;

    logic [10:0]         target;
    logic                trig_valid;
    logic [ADDR_W-1:0]   next_base;
    logic [BIDX_W-1:0]   next_idx;
    logic                last_burst;

    function automatic logic [7:0] len_of(input logic [BIDX_W-1:0] idx);
        return (idx == BIDX_W'(NB - 1)) ? 8'(LAST_LEN) : 8'(BURST_LEN);
    endfunction

    // Trigger decode and line-base accumulator arithmetic (no multiplier).
    always_comb begin
        target     = (y == 11'(V_TOTAL - 1)) ? 11'd0 : (y + 11'd1);
        trig_valid = (x == 12'(H_DISP)) && (target < 11'(V_DISP));
        next_base  = (target == 11'd0) ? BASE_ADDR : (line_base + ADDR_W'(H_DISP));
        next_idx   = burst_idx + BIDX_W'(1);
        last_burst = (burst_idx == BIDX_W'(NB - 1));
    end

    // Fetch FSM: burst sequencing, retrigger handling and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            burst_idx  <= '0;
            pending    <= 1'b0;
            line_base  <= BASE_ADDR;
            rd_req     <= 1'b0;
            rd_addr    <= '0;
            rd_len     <= '0;
            line_ready <= 1'b0;
        end else begin
            if (trig_valid) begin
                line_base <= next_base;
            end
            unique case (state)
                IDLE: begin
                    if (trig_valid) begin
                        state      <= REQ;
                        rd_req     <= 1'b1;
                        rd_addr    <= next_base;
                        rd_len     <= len_of('0);
                        burst_idx  <= '0;
                        line_ready <= 1'b0;
                    end
                end
                REQ: begin
                    // A retrigger never cuts a request short; it is queued.
                    if (rd_ack) begin
                        rd_req <= 1'b0;
                        state  <= WAIT;
                    end
                    if (trig_valid) begin
                        pending <= 1'b1;
                    end
                end
                WAIT: begin
                    if (rd_done) begin
                        // rd_done is resolved first; a same-cycle trigger is
                        // then applied to the resulting state.
                        state   <= REQ;
                        rd_req  <= 1'b1;
                        pending <= trig_valid;
                        if (pending) begin
                            // Abandon the rest of the line, start the queued one.
                            burst_idx <= '0;
                            rd_addr   <= line_base;
                            rd_len    <= len_of('0);
                        end else if (last_burst) begin
                            if (trig_valid) begin
                                burst_idx <= '0;
                                rd_addr   <= next_base;
                                rd_len    <= len_of('0);
                                pending   <= 1'b0;
                            end else begin
                                state      <= IDLE;
                                rd_req     <= 1'b0;
                                line_ready <= 1'b1;
                            end
                        end else begin
                            burst_idx <= next_idx;
                            rd_addr   <= rd_addr + ADDR_W'(BURST_LEN);
                            rd_len    <= len_of(next_idx);
                        end
                    end else if (trig_valid) begin
                        pending <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    rd_req <= 1'b0;
                end
            endcase
        end
    end

    // Underrun detect: first pixel of a visible line with the fetch unfinished.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun <= 1'b0;
        end else begin
            underrun <= (x == 12'd0) && (y < 11'(V_DISP)) && !line_ready;
        end
    end

`ifdef VGA_FETCH_STATS_EN
    // Saturating underrun counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
        end else if (underrun && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`else
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_line_fetch_sched.sv
// Testbench for vga_line_fetch_sched: directed scenarios plus randomized
// line timing and memory latency, checked every cycle against a line/burst
// level model and pinned by hand-computed addresses.
`timescale 1ns/1ps

module tb_vga_line_fetch_sched;

    localparam int H_DISP    = 1680;
    localparam int V_DISP    = 1050;
    localparam int V_TOTAL   = 1089;
    localparam int BURST_LEN = 64;
    localparam int ADDR_W    = 24;
    localparam int NB        = 27;   // ceil(1680/64)
    localparam int LAST_LEN  = 16;   // 1680 - 26*64

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [11:0]       x;
    logic [10:0]       y;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_len;
    logic              rd_ack;
    logic              rd_done;
    logic              line_ready;
    logic              underrun;
    logic [15:0]       underrun_cnt;

    vga_line_fetch_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .x            (x),
        .y            (y),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_len       (rd_len),
        .rd_ack       (rd_ack),
        .rd_done      (rd_done),
        .line_ready   (line_ready),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", name, $time, act, act, exp, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Fetch phase: 0 = no fetch, 1 = request outstanding, 2 = awaiting data.
    int m_phase, m_line, m_burst, m_pend_line, m_cnt, m_t;
    bit m_pend, m_ready, m_under, m_trig;

    function automatic logic [31:0] model_addr();
        longint a;
        a = longint'(m_line) * H_DISP + longint'(m_burst) * BURST_LEN;
        return 32'(a % (64'd1 << ADDR_W));
    endfunction

    function automatic logic [31:0] model_len();
        return (m_burst == NB - 1) ? LAST_LEN : BURST_LEN;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_line = 0; m_burst = 0; m_pend = 0; m_pend_line = 0;
            m_ready = 0; m_under = 0; m_cnt = 0;
        end else begin
`ifdef VGA_FETCH_STATS_EN
            if (m_under && m_cnt < 65535) m_cnt++;
`endif
            m_under = (x == 0) && (int'(y) < V_DISP) && !m_ready;
            m_t     = (int'(y) == V_TOTAL - 1) ? 0 : int'(y) + 1;
            m_trig  = (int'(x) == H_DISP) && (m_t < V_DISP);
            if (m_phase == 1) begin
                if (rd_ack) m_phase = 2;
            end else if (m_phase == 2 && rd_done) begin
                if (m_pend) begin
                    m_line = m_pend_line; m_burst = 0; m_pend = 0; m_phase = 1;
                end else if (m_burst == NB - 1) begin
                    m_phase = 0; m_ready = 1;
                end else begin
                    m_burst++; m_phase = 1;
                end
            end
            if (m_trig) begin
                if (m_phase == 0) begin
                    m_line = m_t; m_burst = 0; m_phase = 1; m_ready = 0;
                end else begin
                    m_pend = 1; m_pend_line = m_t;
                end
            end
        end
    end

    // Per-cycle compare and event counters.
    int u_pulses = 0;
    int req_cycles = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            check("rd_req", rd_req, m_phase == 1);
            if (m_phase == 1) begin
                check("rd_addr", rd_addr, model_addr());
                check("rd_len", rd_len, model_len());
            end
            check("line_ready", line_ready, m_ready);
            check("underrun", underrun, m_under);
            check("underrun_cnt", underrun_cnt, m_cnt);
            if (underrun === 1'b1) u_pulses++;
            if (rd_req === 1'b1) req_cycles++;
        end
    end

    // ---------------- memory responder (driver) ----------------
    bit hold_ack = 0, hold_done = 0, rand_lat = 0, spurious = 0;
    int r_phase = 0, r_cnt = 0;
    logic [ADDR_W-1:0] log_addr[$];
    logic [7:0]        log_len[$];

    function automatic int pick_lat();
        return rand_lat ? int'($urandom_range(0, 3)) : 2;
    endfunction

    initial begin
        rd_ack = 0; rd_done = 0;
        forever begin
            @(negedge clk);
            rd_ack = 0; rd_done = 0;
            if (!rst_n) begin
                r_phase = 0;
            end else begin
                if (r_phase == 0) begin
                    if (rd_req) begin
                        r_cnt = pick_lat(); r_phase = 1;
                    end else if (spurious && $urandom_range(0, 9) == 0) begin
                        rd_done = 1;
                    end
                end
                if (r_phase == 1) begin
                    if (r_cnt > 0) r_cnt--;
                    else if (!hold_ack) begin
                        rd_ack = 1;
                        log_addr.push_back(rd_addr);
                        log_len.push_back(rd_len);
                        r_phase = 2; r_cnt = pick_lat();
                    end
                end else if (r_phase == 2) begin
                    if (r_cnt > 0) r_cnt--;
                    else if (!hold_done) begin
                        rd_done = 1; r_phase = 0;
                    end
                    if (spurious && !rd_done && $urandom_range(0, 7) == 0) rd_ack = 1;
                end
            end
        end
    end

    function automatic logic [31:0] la(input int i);
        if (i >= 0 && i < log_addr.size()) return 32'(log_addr[i]);
        return 'x;
    endfunction

    function automatic logic [31:0] ll(input int i);
        if (i >= 0 && i < log_len.size()) return 32'(log_len[i]);
        return 'x;
    endfunction

    task automatic clear_log();
        log_addr.delete();
        log_len.delete();
    endtask

    // ---------------- timing driver tasks ----------------
    task automatic step(input int xv, input int yv);
        @(negedge clk);
        x = 12'(xv);
        y = 11'(yv);
    endtask

    task automatic run_line(input int yv, input int blank);
        step(0, yv);
        repeat (3) step(1, yv);
        step(H_DISP, yv);
        repeat (blank) step(H_DISP + 1, yv);
    endtask

    // ---------------- scenarios ----------------
    int u0, r0;
    logic [31:0] exp_cnt;

    initial begin
        x = 12'(H_DISP + 1);
        y = 11'(V_TOTAL - 1);
        repeat (3) @(negedge clk);
        #1;
        check("reset_rd_req", rd_req, 0);
        check("reset_rd_addr", rd_addr, 0);
        check("reset_rd_len", rd_len, 0);
        check("reset_line_ready", line_ready, 0);
        check("reset_underrun", underrun, 0);
        check("reset_underrun_cnt", underrun_cnt, 0);
        @(negedge clk);
        rst_n = 1;

        // Frame start, 2-cycle memory latency.
        clear_log();
        u0 = u_pulses;
        run_line(1088, 400);
        check("f0_bursts", log_addr.size(), NB);
        check("f0_addr0", la(0), 0);
        check("f0_addr1", la(1), 64);
        check("f0_addr_last", la(NB - 1), 1664);
        check("f0_len0", ll(0), 64);
        check("f0_len25", ll(NB - 2), 64);
        check("f0_len_last", ll(NB - 1), 16);
        check("f0_ready_before_y0", line_ready, 1);

        // Line 1 fetch (trigger on y=0); x=0,y=0 must not underrun.
        clear_log();
        run_line(0, 400);
        check("f0_no_underrun", u_pulses - u0, 0);
        check("l1_bursts", log_addr.size(), NB);
        check("l1_addr_first", la(0), 1680);
        check("l1_addr_last", la(NB - 1), 3344);

        // Lines 2..4 with random latency.
        rand_lat = 1;
        for (int yy = 1; yy <= 3; yy++) run_line(yy, 400);

        // Retrigger: stall rd_done during line-5 fetch past the line-6 trigger.
        clear_log();
        u0 = u_pulses;
        hold_done = 1;
        step(0, 4); step(1, 4); step(H_DISP, 4);
        repeat (20) step(H_DISP + 1, 4);
        step(0, 5); step(1, 5); step(H_DISP, 5);
        repeat (3) step(H_DISP + 1, 5);
        hold_done = 0;
        repeat (400) step(H_DISP + 1, 5);
        check("rt_bursts", log_addr.size(), 1 + NB);
        check("rt_line5_first", la(0), 8400);
        check("rt_restart_addr", la(1), 10080);
        check("rt_last_addr", la(NB), 11744);
        check("rt_last_len", ll(NB), 16);
        check("rt_underrun_once", u_pulses - u0, 1);

        // Reset mid-burst.
        step(0, 6); step(1, 6); step(H_DISP, 6);
        for (int i = 0; i < 10 && !rd_req; i++) step(H_DISP + 1, 6);
        check("rst_req_before", rd_req, 1);
        #2 rst_n = 0;
        #1;
        check("rst_async_rd_req", rd_req, 0);
        check("rst_async_rd_addr", rd_addr, 0);
        check("rst_async_rd_len", rd_len, 0);
        check("rst_async_line_ready", line_ready, 0);
        check("rst_async_underrun", underrun, 0);
        check("rst_async_cnt", underrun_cnt, 0);
        x = 12'(H_DISP + 1);
        repeat (3) @(negedge clk);
        rst_n = 1;
        clear_log();
        step(1, 0); step(H_DISP, 0);
        repeat (400) step(H_DISP + 1, 0);
        check("post_rst_bursts", log_addr.size(), NB);
        check("post_rst_addr_first", la(0), 1680);
        check("post_rst_addr_last", la(NB - 1), 3344);

        // Vertical blanking: targets >= V_DISP issue nothing.
        r0 = req_cycles;
        for (int yy = 1049; yy <= 1087; yy++) run_line(yy, 5);
        check("blank_no_req", req_cycles - r0, 0);

        // Underrun: memory never accepts the frame-start fetch.
        hold_ack = 1;
        u0 = u_pulses;
        run_line(1088, 50);
        step(0, 0);
        repeat (5) step(1, 0);
        check("ur_pulse_once", u_pulses - u0, 1);
`ifdef VGA_FETCH_STATS_EN
        exp_cnt = 1;
`else
        exp_cnt = 0;
`endif
        check("ur_cnt", underrun_cnt, exp_cnt);
        hold_ack = 0;

        // Randomized line timing, latency and stray handshake pulses.
        spurious = 1;
        for (int yy = 0; yy < 40; yy++) run_line(yy, int'($urandom_range(20, 400)));
        run_line(1088, 400);
        run_line(0, 400);
        spurious = 0;
        repeat (10) step(H_DISP + 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
